// File: rtl/coin_charge_ctrl.sv
// Coin-credit front end for the charge timer: debounces the coin switch, keeps a
// saturating credit count and launches one timer segment per credit.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | no segment active; launch when credit > 0 and timer idle
//   LAUNCH   | one-cycle start pulse, credit spent
//   WAIT_ACK | waiting up to ACKWAIT cycles for the timer to raise timing
//   RUN      | segment in progress, waiting for timing to fall
module coin_charge_ctrl #(
  parameter int DEBOUNCE  = 1000000,
  parameter int MAXCREDIT = 9,
  parameter int ACKWAIT   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin,
  input  logic       cancel,
  input  logic       timing,
  output logic       start,
  output logic [3:0] credit,
  output logic       charging,
  output logic       full,
  output logic       fault
);

  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int AW = (ACKWAIT > 1) ? $clog2(ACKWAIT) : 1;
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE - 1);
  localparam logic [AW-1:0] ACK_LAST   = AW'(ACKWAIT - 1);
  localparam logic [3:0]    CREDIT_MAX = 4'(MAXCREDIT);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACK, RUN} state_t;

  state_t        state, state_next;
  logic          sync1, sync2, stable, stable_d, coin_evt;
  logic [DW-1:0] db_cnt;
  logic [AW-1:0] ack_cnt, ack_cnt_next;
  logic          dec, refund, fault_set;
  logic [4:0]    credit_sum;
  logic [3:0]    credit_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      coin_evt <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync1    <= coin;
      sync2    <= sync1;
      stable_d <= stable;
      coin_evt <= stable & ~stable_d;
      if (sync2 != stable) begin
        if (db_cnt == DB_LAST) begin
          stable <= sync2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // coin+decrement cancels out; coin+refund may overshoot and is clamped
  always_comb begin
    credit_sum = {1'b0, credit} + {4'b0, coin_evt} + {4'b0, refund} - {4'b0, dec};
    if (cancel)
      credit_next = '0;
    else if (credit_sum > {1'b0, CREDIT_MAX})
      credit_next = CREDIT_MAX;
    else
      credit_next = credit_sum[3:0];
  end

  always_comb begin
    state_next   = state;
    ack_cnt_next = ack_cnt;
    start        = 1'b0;
    dec          = 1'b0;
    refund       = 1'b0;
    fault_set    = 1'b0;
    case (state)
      IDLE: begin
        // a cancel in this cycle empties credit, so LAUNCH would have nothing to spend
        if (credit != 4'd0 && !timing && !cancel)
          state_next = LAUNCH;
      end
      LAUNCH: begin
        start        = 1'b1;
        dec          = 1'b1;
        ack_cnt_next = ACK_LAST;
        state_next   = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (timing) begin
          state_next = RUN;
        end else if (ack_cnt == '0) begin
          refund     = 1'b1;
          fault_set  = 1'b1;
          state_next = IDLE;
        end else begin
          ack_cnt_next = ack_cnt - 1'b1;
        end
      end
      RUN: begin
        if (!timing)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      ack_cnt <= '0;
      credit  <= '0;
      fault   <= 1'b0;
    end else begin
      state   <= state_next;
      ack_cnt <= ack_cnt_next;
      credit  <= credit_next;
      if (fault_set)
        fault <= 1'b1;
    end
  end

  assign charging = (state != IDLE);
  assign full     = (credit == CREDIT_MAX);

endmodule

// File: tb/tb_coin_charge_ctrl.sv
// Self-checking bench for coin_charge_ctrl with a behavioural charge-timer model
// and a start-pulse scoreboard (credit seen at each start, gap after timing fall).
module tb_coin_charge_ctrl;

  typedef struct {
    int credit;
    int gap;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       coin = 1'b0;
  logic       cancel = 1'b0;
  logic       timing = 1'b0;
  logic       start;
  logic [3:0] credit;
  logic       charging;
  logic       full;
  logic       fault;

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  tcnt = 0;
  int  seg_len = 10;
  bit  timer_en = 1'b1;
  bit  sb_en = 1'b1;
  int  long_starts = 0;
  int  fall_cyc = -1000;
  bit  prev_start = 1'b0;
  bit  prev_timing = 1'b0;
  ev_t exp_q[$];
  ev_t obs_q[$];

  coin_charge_ctrl #(.DEBOUNCE(4), .MAXCREDIT(9), .ACKWAIT(4)) dut (
    .clk(clk), .reset(reset), .coin(coin), .cancel(cancel), .timing(timing),
    .start(start), .credit(credit), .charging(charging), .full(full), .fault(fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // timer: latches start, raises timing next cycle, holds it for seg_len cycles
  always @(posedge clk) begin
    if (!timer_en) timing <= 1'b0;
    else if (start) begin
      timing <= 1'b1;
      tcnt   <= seg_len - 1;
    end else if (tcnt > 0) tcnt <= tcnt - 1;
    else timing <= 1'b0;
  end

  always @(negedge clk) begin
    ev_t ev;
    if (start === 1'b1) begin
      if (sb_en) begin
        ev.credit = int'(credit);
        ev.gap    = cyc - fall_cyc;
        obs_q.push_back(ev);
      end
      if (prev_start) long_starts++;
    end
    if (prev_timing && !timing) fall_cyc = cyc;
    prev_start  = (start === 1'b1);
    prev_timing = timing;
  end

  function automatic ev_t mk(input int c, input int g);
    ev_t e;
    e.credit = c;
    e.gap    = g;
    return e;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic insert_coin();
    coin = 1'b1;
    step(10);
    coin = 1'b0;
    step(10);
  endtask

  task automatic wait_quiet(input int bound, output bit ok);
    int run = 0;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!charging && !timing) run++;
      else run = 0;
      if (run >= 3) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(3);
    checks++;
    if ({start, charging, full, fault, credit} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b, want 00000000", {start, charging, full, fault, credit});
    end
    reset = 1'b1;
    step(2);
  endtask

  task automatic test_bounce();
    bit saw_start = 1'b0;
    bit saw_credit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i < 20 && i % 2 == 0) coin = ~coin;
      if (i == 20) coin = 1'b0;
      @(negedge clk);
      if (start) saw_start = 1'b1;
      if (credit != 4'd0) saw_credit = 1'b1;
    end
    checks++;
    if (saw_credit) begin
      errors++;
      $display("FAIL bounce_credit: credit became nonzero, want 0");
    end
    checks++;
    if (saw_start || obs_q.size() != 0) begin
      errors++;
      $display("FAIL bounce_start: start seen=%0d, want 0", saw_start);
    end
    obs_q.delete();
  endtask

  task automatic test_single();
    bit saw1 = 1'b0;
    bit seen = 1'b0;
    ev_t e, o;
    seg_len = 10;
    exp_q.push_back(mk(1, -1));
    coin = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (credit == 4'd1) saw1 = 1'b1;
    end
    coin = 1'b0;
    checks++;
    if (!saw1) begin
      errors++;
      $display("FAIL single_credit: credit never 1, want 1");
    end
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (!timing) seen = 1'b1;
    end
    checks++;
    if (!seen || charging !== 1'b1) begin
      errors++;
      $display("FAIL single_fall: fall seen=%0d charging=%b, want 1/1", seen, charging);
    end
    step(1);
    checks++;
    if (charging !== 1'b0 || credit !== 4'd0) begin
      errors++;
      $display("FAIL single_end: charging=%b credit=%0d, want 0/0", charging, credit);
    end
    step(10);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL single_count: got %0d starts, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.credit != e.credit || (e.gap >= 0 && o.gap != e.gap)) begin
        errors++;
        $display("FAIL single_start: credit=%0d gap=%0d, want credit=%0d gap=%0d", o.credit, o.gap, e.credit, e.gap);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    bit ok;
    ev_t e, o;
    seg_len = 100;
    exp_q.push_back(mk(1, -1));
    exp_q.push_back(mk(3, 2));
    exp_q.push_back(mk(2, 2));
    exp_q.push_back(mk(1, 2));
    insert_coin();
    repeat (3) insert_coin();
    checks++;
    if (credit !== 4'd3 || full !== 1'b0) begin
      errors++;
      $display("FAIL chain_credit: credit=%0d full=%b, want 3/0", credit, full);
    end
    wait_quiet(600, ok);
    checks++;
    if (!ok || credit !== 4'd0 || charging !== 1'b0) begin
      errors++;
      $display("FAIL chain_end: quiet=%0d credit=%0d charging=%b, want 1/0/0", ok, credit, charging);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL chain_count: got %0d starts, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.credit != e.credit || (e.gap >= 0 && o.gap != e.gap)) begin
        errors++;
        $display("FAIL chain_start: credit=%0d gap=%0d, want credit=%0d gap=%0d", o.credit, o.gap, e.credit, e.gap);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_saturate_cancel();
    bit ok;
    int want;
    ev_t e, o;
    seg_len = 400;
    exp_q.push_back(mk(1, -1));
    insert_coin();
    for (int i = 1; i <= 12; i++) begin
      insert_coin();
      want = (i > 9) ? 9 : i;
      checks++;
      if (credit !== 4'(want) || full !== (i >= 9)) begin
        errors++;
        $display("FAIL sat_coin%0d: credit=%0d full=%b, want %0d/%0d", i, credit, full, want, (i >= 9));
      end
    end
    cancel = 1'b1;
    step(1);
    cancel = 1'b0;
    checks++;
    if (credit !== 4'd0 || full !== 1'b0 || charging !== 1'b1) begin
      errors++;
      $display("FAIL cancel_run: credit=%0d full=%b charging=%b, want 0/0/1", credit, full, charging);
    end
    wait_quiet(400, ok);
    step(20);
    checks++;
    if (!ok || charging !== 1'b0) begin
      errors++;
      $display("FAIL cancel_end: quiet=%0d charging=%b, want 1/0", ok, charging);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL cancel_count: got %0d starts, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.credit != e.credit) begin
        errors++;
        $display("FAIL cancel_start: credit=%0d, want %0d", o.credit, e.credit);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_fault();
    bit found = 1'b0;
    bit ok;
    sb_en = 1'b0;
    timer_en = 1'b0;
    seg_len = 10;
    coin = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (start) found = 1'b1;
    end
    coin = 1'b0;
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL fault_launch: no start within 40 cycles, want start");
    end
    step(4);
    checks++;
    if (fault !== 1'b0 || credit !== 4'd0 || charging !== 1'b1) begin
      errors++;
      $display("FAIL fault_wait: fault=%b credit=%0d charging=%b, want 0/0/1", fault, credit, charging);
    end
    step(1);
    checks++;
    if (fault !== 1'b1 || credit !== 4'd1 || charging !== 1'b0) begin
      errors++;
      $display("FAIL fault_refund: fault=%b credit=%0d charging=%b, want 1/1/0", fault, credit, charging);
    end
    step(1);
    timer_en = 1'b1;
    checks++;
    if (start !== 1'b1) begin
      errors++;
      $display("FAIL fault_relaunch: start=%b, want 1", start);
    end
    wait_quiet(100, ok);
    checks++;
    if (!ok || fault !== 1'b1 || credit !== 4'd0) begin
      errors++;
      $display("FAIL fault_sticky: quiet=%0d fault=%b credit=%0d, want 1/1/0", ok, fault, credit);
    end
    sb_en = 1'b1;
    obs_q.delete();
  endtask

  task automatic test_launch_coin_reset();
    bit found = 1'b0;
    bit ok;
    int s = 0;
    ev_t e, o;
    seg_len = 100;
    exp_q.push_back(mk(1, -1));
    exp_q.push_back(mk(1, 2));
    exp_q.push_back(mk(1, 2));
    exp_q.push_back(mk(1, -1));
    coin = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (start) begin
        found = 1'b1;
        s = cyc;
      end
    end
    coin = 1'b0;
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL lc_first: no start within 20 cycles, want start");
    end
    step(20);
    insert_coin();
    checks++;
    if (credit !== 4'd1) begin
      errors++;
      $display("FAIL lc_queued: credit=%0d, want 1", credit);
    end
    // coin_evt lands 7 cycles after the raw rise; LAUNCH is 3 cycles past segment end
    while (cyc < s + seg_len - 4) @(negedge clk);
    coin = 1'b1;
    while (cyc < s + seg_len + 3) @(negedge clk);
    checks++;
    if (start !== 1'b1 || credit !== 4'd1) begin
      errors++;
      $display("FAIL lc_launch: start=%b credit=%0d, want 1/1", start, credit);
    end
    step(1);
    coin = 1'b0;
    checks++;
    if (credit !== 4'd1) begin
      errors++;
      $display("FAIL lc_unchanged: credit=%0d, want 1", credit);
    end
    found = 1'b0;
    for (int i = 0; i < 250 && !found; i++) begin
      @(negedge clk);
      if (start) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL lc_third: no start within 250 cycles, want start");
    end
    step(20);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    checks++;
    if ({start, charging, full, fault, credit} !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid: got %b, want 00000000", {start, charging, full, fault, credit});
    end
    insert_coin();
    checks++;
    if (credit !== 4'd1 || charging !== 1'b0 || timing !== 1'b1) begin
      errors++;
      $display("FAIL rst_hold: credit=%0d charging=%b timing=%b, want 1/0/1", credit, charging, timing);
    end
    wait_quiet(300, ok);
    checks++;
    if (!ok || credit !== 4'd0) begin
      errors++;
      $display("FAIL rst_resume: quiet=%0d credit=%0d, want 1/0", ok, credit);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL lc_count: got %0d starts, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.credit != e.credit || (e.gap >= 0 && o.gap != e.gap)) begin
        errors++;
        $display("FAIL lc_start: credit=%0d gap=%0d, want credit=%0d gap=%0d", o.credit, o.gap, e.credit, e.gap);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_single();
    test_back_to_back();
    test_saturate_cancel();
    test_fault();
    test_launch_coin_reset();
    checks++;
    if (long_starts != 0) begin
      errors++;
      $display("FAIL start_width: %0d multi-cycle start pulses, want 0", long_starts);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
